fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Instruction-memory / datapath / PC-select bundle of fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        exec_done;
    logic        zero_flag;
    logic        stall;
    logic        resume;
    logic        mem_req;
    logic [15:0] IR;
    logic        instr_valid;
    logic [1:0]  PC_MUX;
    logic [1:0]  PC_DIRECT_CH;
    logic        halted;
    logic        fetch_err;
    logic [15:0] retired;

    // master: the controller itself; slave: memory, datapath and PC logic
    modport master (
        input  mem_ack, mem_rdata, exec_done, zero_flag, stall, resume,
        output mem_req, IR, instr_valid, PC_MUX, PC_DIRECT_CH, halted,
               fetch_err, retired
    );
    modport slave (
        output mem_ack, mem_rdata, exec_done, zero_flag, stall, resume,
        input  mem_req, IR, instr_valid, PC_MUX, PC_DIRECT_CH, halted,
               fetch_err, retired
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch/execute sequencer with branch decode and fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_ctrl_if.master bus
);
    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [15:0]          r_ir;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [15:0]          r_retired;
    logic                 r_fetch_err;

    logic                 w_done;
    logic                 w_is_halt;
    logic [1:0]           w_pc_mux;
    logic [1:0]           w_direct_ch;
    logic                 w_mem_req;
    logic                 w_instr_valid;
    logic                 w_halted;

    assign w_done    = (r_state == S_EXEC) && bus.exec_done && !bus.stall;
    assign w_is_halt = (r_ir[15:12] == 4'hF) && (r_ir[11:0] == 12'h000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_ir        <= 16'h0000;
            r_cnt       <= '0;
            r_retired   <= 16'h0000;
            r_fetch_err <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_FETCH;
                S_FETCH: begin
                    // A late acknowledge still beats the timeout in the same cycle
                    if (bus.mem_ack) begin
                        r_ir    <= bus.mem_rdata;
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else if (r_cnt == c_TIMEOUT) begin
                        r_cnt       <= '0;
                        r_fetch_err <= 1'b1;
                        r_state     <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_EXEC: begin
                    if (w_done) begin
                        r_retired <= r_retired + 16'd1;
                        r_state   <= w_is_halt ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        r_fetch_err <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        w_pc_mux      = 2'b00;
        w_direct_ch   = 2'b00;
        w_mem_req     = 1'b0;
        w_instr_valid = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            S_INIT:  w_pc_mux  = 2'b11;
            S_FETCH: w_mem_req = 1'b1;
            S_EXEC: begin
                w_instr_valid = 1'b1;
                if (w_done) begin
                    case (r_ir[15:12])
                        4'hC: begin w_pc_mux = 2'b01; w_direct_ch = 2'b01; end
                        4'hD: begin w_pc_mux = 2'b01; w_direct_ch = 2'b10; end
                        4'hE: begin
                            // Taken branch selects RESULT_PC, channel 00
                            w_pc_mux = bus.zero_flag ? 2'b01 : 2'b10;
                        end
                        4'hF:    w_pc_mux = w_is_halt ? 2'b00 : 2'b10;
                        default: w_pc_mux = 2'b10;
                    endcase
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (bus.resume) w_pc_mux = 2'b10;
            end
            default: w_pc_mux = 2'b11;
        endcase
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.IR           = r_ir;
    assign bus.instr_valid  = w_instr_valid;
    assign bus.PC_MUX       = w_pc_mux;
    assign bus.PC_DIRECT_CH = w_direct_ch;
    assign bus.halted       = w_halted;
    assign bus.fetch_err    = r_fetch_err;
    assign bus.retired      = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed plus randomized bench for fetch_ctrl with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    localparam int TIMEOUT = 15;
    localparam int M_INIT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // reference model: activity, instruction, cycles waited, counters
    int          m_mode;
    logic [15:0] m_ir;
    int          m_wait;
    logic [15:0] m_ret;
    logic        m_err;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] e_pm;
        logic [1:0] e_ch;
        logic       completes;
        e_pm = 2'b00;
        e_ch = 2'b00;
        completes = (m_mode == M_EXEC) && bus.exec_done && !bus.stall;
        if (m_mode == M_INIT) e_pm = 2'b11;
        if (m_mode == M_HALT && bus.resume) e_pm = 2'b10;
        if (completes) begin
            if (m_ir == 16'hF000)          e_pm = 2'b00;
            else if (m_ir[15:12] == 4'hC) begin e_pm = 2'b01; e_ch = 2'b01; end
            else if (m_ir[15:12] == 4'hD) begin e_pm = 2'b01; e_ch = 2'b10; end
            else if (m_ir[15:12] == 4'hE) e_pm = bus.zero_flag ? 2'b01 : 2'b10;
            else                          e_pm = 2'b10;
        end
        cmp({tag, ".pc_mux"},      16'(bus.PC_MUX),       16'(e_pm));
        cmp({tag, ".direct_ch"},   16'(bus.PC_DIRECT_CH), 16'(e_ch));
        cmp({tag, ".mem_req"},     16'(bus.mem_req),      16'(m_mode == M_FETCH));
        cmp({tag, ".instr_valid"}, 16'(bus.instr_valid),  16'(m_mode == M_EXEC));
        cmp({tag, ".halted"},      16'(bus.halted),       16'(m_mode == M_HALT));
        cmp({tag, ".ir"},          bus.IR,                m_ir);
        cmp({tag, ".fetch_err"},   16'(bus.fetch_err),    16'(m_err));
        cmp({tag, ".retired"},     bus.retired,           m_ret);
    endtask

    task automatic model_reset();
        m_mode = M_INIT;
        m_ir   = 16'h0000;
        m_wait = 0;
        m_ret  = 16'h0000;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        case (m_mode)
            M_INIT: m_mode = M_FETCH;
            M_FETCH: begin
                if (bus.mem_ack) begin
                    m_ir = bus.mem_rdata; m_wait = 0; m_mode = M_EXEC;
                end else if (m_wait == TIMEOUT) begin
                    m_err = 1'b1; m_wait = 0; m_mode = M_HALT;
                end else begin
                    m_wait++;
                end
            end
            M_EXEC: begin
                if (bus.exec_done && !bus.stall) begin
                    m_ret  = m_ret + 16'd1;
                    m_mode = (m_ir == 16'hF000) ? M_HALT : M_FETCH;
                end
            end
            default: begin
                if (bus.resume) begin m_err = 1'b0; m_mode = M_FETCH; end
            end
        endcase
    endtask

    // inputs are already applied; check at negedge, then let the edge happen
    task automatic cycle(input string tag);
        @(negedge clk);
        check_all(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000; bus.exec_done = 1'b0;
        bus.zero_flag = 1'b0; bus.stall = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic fetch_instr(input logic [15:0] v, input string tag);
        bus.mem_ack = 1'b1; bus.mem_rdata = v;
        cycle(tag);
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000;
    endtask

    task automatic exec_once(input logic zf, input string tag);
        bus.exec_done = 1'b1; bus.zero_flag = zf;
        cycle(tag);
        bus.exec_done = 1'b0; bus.zero_flag = 1'b0;
    endtask

    initial begin
        int drought;
        logic [15:0] v;
        total = 0;
        bad   = 0;
        drought = 0;
        clear_inputs();
        model_reset();
        do_reset("por");

        // basic fetch with one wait cycle, then plain instruction
        cycle("init");
        cycle("fetch_wait");
        fetch_instr(16'h1234, "fetch_1234");
        exec_once(1'b0, "exec_1234");

        fetch_instr(16'hC05A, "fetch_jmp");
        exec_once(1'b0, "exec_jmp");
        fetch_instr(16'hD3A1, "fetch_jr");
        exec_once(1'b0, "exec_jr");
        fetch_instr(16'hE000, "fetch_beq_t");
        exec_once(1'b1, "exec_beq_t");
        fetch_instr(16'hE000, "fetch_beq_nt");
        exec_once(1'b0, "exec_beq_nt");
        fetch_instr(16'hF001, "fetch_fnz");
        exec_once(1'b0, "exec_fnz");

        // stall overrides exec_done
        fetch_instr(16'h1111, "fetch_stall");
        bus.stall = 1'b1; bus.exec_done = 1'b1;
        repeat (3) cycle("exec_stalled");
        bus.stall = 1'b0;
        cycle("exec_unstall");
        bus.exec_done = 1'b0;

        // timeout into HALT, then resume
        repeat (TIMEOUT + 1) cycle("fetch_timeout");
        cycle("halt_err");
        bus.resume = 1'b1;
        cycle("halt_resume");
        bus.resume = 1'b0;

        // acknowledge in the very last allowed cycle
        repeat (TIMEOUT) cycle("fetch_late");
        fetch_instr(16'h2222, "fetch_late_ack");
        exec_once(1'b0, "exec_late");

        // HALT instruction, then reset while halted
        fetch_instr(16'hF000, "fetch_halt");
        exec_once(1'b0, "exec_halt");
        bus.resume = 1'b0;
        cycle("halt_idle");
        do_reset("rst_halt");

        // reset mid-EXEC with a completion pending
        cycle("init2");
        fetch_instr(16'hC123, "fetch_pre_rst");
        bus.exec_done = 1'b1;
        do_reset("rst_exec");
        bus.exec_done = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (drought == 0 && $urandom_range(0, 59) == 0) drought = TIMEOUT + 3;
            if (drought > 0) begin
                drought--;
                bus.mem_ack = 1'b0;
            end else begin
                bus.mem_ack = ($urandom_range(0, 2) == 0);
            end
            v = 16'($urandom);
            case ($urandom_range(0, 5))
                0: bus.mem_rdata = {4'hC, v[11:0]};
                1: bus.mem_rdata = {4'hD, v[11:0]};
                2: bus.mem_rdata = {4'hE, v[11:0]};
                3: bus.mem_rdata = 16'hF000;
                4: bus.mem_rdata = {4'hF, v[11:1], 1'b1};
                default: bus.mem_rdata = v;
            endcase
            bus.exec_done = ($urandom_range(0, 1) == 1);
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.zero_flag = ($urandom_range(0, 1) == 1);
            bus.resume    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) do_reset("rst_rand");
            else cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
